// File: rtl/serial_frame_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_frame_tx_pkg
// Shared definitions for the serial frame transmitter:
//   - state_t      : FSM state encoding (IDLE=0, START=1, DATA=2, PARITY=3,
//                    STOP=4), 3 bits wide
//   - LINE_IDLE    : level of the serial line when no frame is in progress
//   - START_LEVEL  : level driven during the start bit
//   - STOP_LEVEL   : level driven during the stop bit
// -----------------------------------------------------------------------------
package serial_frame_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage : serial_frame_tx_pkg

// File: rtl/serial_frame_tx_bit_timer.sv
// -----------------------------------------------------------------------------
// serial_bit_timer
// Counts clock cycles within one serial bit period. The counter runs
// 0..CLKS_PER_BIT-1 while enabled and wraps to 0 on every bit boundary;
// bit_done pulses for one cycle in the last cycle of each bit.
//
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (>= 1)
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   enable   in   count while high; counter held at 0 while low
//   bit_done out  high in the final cycle of a bit period
// -----------------------------------------------------------------------------
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic bit_done
);

  // A single-cycle bit still needs a 1-bit counter so the logic stays legal.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is written with non-blocking (<=) assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_done = enable && (cnt == CNT_LAST);

endmodule : serial_bit_timer

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
// Parallel-in, serial-out frame transmitter. Accepts a DATA_W-bit word on a
// valid/ready handshake and shifts it out LSB-first framed by a start bit (0)
// and a stop bit (1), each bit held for CLKS_PER_BIT clocks. All outputs are
// registered.
//
// Build option:
//   SERIAL_TX_PARITY_EN : when defined, an even-parity bit (XOR of the word,
//                         computed at acceptance) is sent between the last
//                         data bit and the stop bit.
//
// Parameters:
//   DATA_W       : payload bits per frame (>= 1)
//   CLKS_PER_BIT : clock cycles per serial bit (>= 1)
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   tx_data   in   word to send, sampled only on handshake
//   tx_valid  in   tx_data is valid
//   tx_ready  out  word can be accepted this cycle (IDLE only)
//   tx_out    out  serial line, idles high
//   busy      out  frame in progress
// -----------------------------------------------------------------------------
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              tx_out_d, busy_d, tx_ready_d;
  logic              bit_done;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  serial_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (state_q != ST_IDLE),
    .bit_done (bit_done)
  );

  // Next-state logic; outputs are decoded from the *next* state so that the
  // registered outputs line up with the state register on the same edge.
  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready) begin
          state_d   = ST_START;
          shift_d   = tx_data;
          bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          // Counter stops at DATA_W, which its width can always hold.
          if (bit_cnt_d == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_out_d = START_LEVEL;
      ST_DATA:   tx_out_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: tx_out_d = parity_d;
`endif
      ST_STOP:   tx_out_d = STOP_LEVEL;
      default:   tx_out_d = LINE_IDLE;
    endcase

    busy_d     = (state_d != ST_IDLE);
    tx_ready_d = (state_d == ST_IDLE);
  end

  // The shift register is cleared on reset as well, so a frame aborted by
  // reset leaves nothing behind to resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_out    <= LINE_IDLE;
      busy      <= 1'b0;
      tx_ready  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_out    <= tx_out_d;
      busy      <= busy_d;
      tx_ready  <= tx_ready_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule : serial_frame_tx
